// File: rtl/nibble_frame_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : nibble_frame_tx                                                |
// | Brief   : MII-style nibble framer (preamble, SFD, payload, XOR FCS, IFG) |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module nibble_frame_tx #(
  parameter int PAYLOAD_NIBBLES = 16,
  parameter int IFG_CYCLES      = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] txd,
  output logic       tx_en,
  output logic       tx_er,
  output logic [7:0] frame_cnt,
  output logic [7:0] underrun_cnt,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRE     = 3'd1,
    S_SFD     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_FCS     = 3'd4,
    S_IFG     = 3'd5
  } state_t;

  localparam logic [7:0] C_PRE_LAST = 8'd14;
  localparam logic [7:0] C_PAY_LAST = 8'(PAYLOAD_NIBBLES - 1);
  localparam logic [7:0] C_IFG_LAST = 8'(IFG_CYCLES - 1);

  state_t     r_state, w_state;
  logic [7:0] r_idx, w_idx;
  logic [3:0] r_csum, w_csum;
  logic [3:0] r_txd, w_txd;
  logic       r_tx_en, w_tx_en;
  logic       r_tx_er, w_tx_er;
  logic       r_abort, w_abort;
  logic       w_frame_inc, w_under_inc;
  logic [7:0] r_frame_cnt, r_under_cnt;

  // r_abort marks the single underrun cycle, which stays in PAYLOAD with no ready
  assign in_ready = (r_state == S_SFD) ||
                    ((r_state == S_PAYLOAD) && !r_abort && (r_idx < C_PAY_LAST));

  always_comb begin
    w_state     = r_state;
    w_idx       = r_idx;
    w_csum      = r_csum;
    w_txd       = 4'h0;
    w_tx_en     = 1'b0;
    w_tx_er     = 1'b0;
    w_abort     = 1'b0;
    w_frame_inc = 1'b0;
    w_under_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state = S_PRE;
          w_idx   = 8'd0;
          w_csum  = 4'h0;
          w_txd   = 4'h5;
          w_tx_en = 1'b1;
        end
      end
      S_PRE: begin
        w_tx_en = 1'b1;
        if (r_idx == C_PRE_LAST) begin
          w_state = S_SFD;
          w_idx   = 8'd0;
          w_txd   = 4'hD;
        end else begin
          w_idx = r_idx + 8'd1;
          w_txd = 4'h5;
        end
      end
      S_SFD, S_PAYLOAD: begin
        if (r_abort) begin
          w_state = S_IFG;
          w_idx   = 8'd0;
        end else if (in_ready) begin
          w_state = S_PAYLOAD;
          w_idx   = (r_state == S_SFD) ? 8'd0 : r_idx + 8'd1;
          w_tx_en = 1'b1;
          if (in_valid) begin
            w_txd  = in_data;
            w_csum = r_csum ^ in_data;
          end else begin
            w_abort     = 1'b1;
            w_tx_er     = 1'b1;
            w_under_inc = 1'b1;
          end
        end else begin
          w_state = S_FCS;
          w_txd   = r_csum;
          w_tx_en = 1'b1;
        end
      end
      S_FCS: begin
        w_state     = S_IFG;
        w_idx       = 8'd0;
        w_frame_inc = 1'b1;
      end
      S_IFG: begin
        if (r_idx == C_IFG_LAST) begin
          w_state = S_IDLE;
          w_idx   = 8'd0;
        end else begin
          w_idx = r_idx + 8'd1;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_idx   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= 8'd0;
      r_csum      <= 4'h0;
      r_txd       <= 4'h0;
      r_tx_en     <= 1'b0;
      r_tx_er     <= 1'b0;
      r_abort     <= 1'b0;
      r_frame_cnt <= 8'd0;
      r_under_cnt <= 8'd0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_csum  <= w_csum;
      r_txd   <= w_txd;
      r_tx_en <= w_tx_en;
      r_tx_er <= w_tx_er;
      r_abort <= w_abort;
      if (w_frame_inc) r_frame_cnt <= r_frame_cnt + 8'd1;
      if (w_under_inc && (r_under_cnt != 8'hFF)) r_under_cnt <= r_under_cnt + 8'd1;
    end
  end

  assign txd          = r_txd;
  assign tx_en        = r_tx_en;
  assign tx_er        = r_tx_er;
  assign frame_cnt    = r_frame_cnt;
  assign underrun_cnt = r_under_cnt;
  assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_nibble_frame_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module  : tb_nibble_frame_tx                                             |
// | Brief   : self-checking bench for nibble_frame_tx                        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_nibble_frame_tx;
  localparam int N   = 16;
  localparam int IFG = 24;

  typedef logic [3:0] pay_t [N];
  typedef struct {
    int         kind;
    logic [3:0] base;
    int         u;
    logic [3:0] fcs;
    logic [7:0] frames;
    logic [7:0] unders;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data;
  logic       in_valid, in_ready, tx_en, tx_er, busy;
  logic [3:0] txd;
  logic [7:0] frame_cnt, underrun_cnt;

  logic [3:0] d3, txd3;
  logic       v3, ready3, en3, er3, busy3;
  logic [7:0] fc3, uc3;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         start_obs = 0;
  logic [7:0] m_frames = 8'd0;
  logic [7:0] m_under = 8'd0;

  nibble_frame_tx dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .txd(txd), .tx_en(tx_en), .tx_er(tx_er), .frame_cnt(frame_cnt),
    .underrun_cnt(underrun_cnt), .busy(busy)
  );

  nibble_frame_tx #(.PAYLOAD_NIBBLES(3), .IFG_CYCLES(4)) dut3 (
    .clk(clk), .rst(rst), .in_data(d3), .in_valid(v3), .in_ready(ready3),
    .txd(txd3), .tx_en(en3), .tx_er(er3), .frame_cnt(fc3),
    .underrun_cnt(uc3), .busy(busy3)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic mk(input int kind, input logic [3:0] base, output pay_t d);
    for (int j = 0; j < N; j++) begin
      case (kind)
        0:       d[j] = base + 4'(j);
        1:       d[j] = (j == 0) ? base : 4'h0;
        2:       d[j] = (j == 0) ? base : ((j == 5) ? 4'h3 : 4'h0);
        default: d[j] = 4'($urandom);
      endcase
    end
  endtask

  function automatic logic [3:0] xor_all(input pay_t d);
    logic [3:0] x = 4'h0;
    for (int j = 0; j < N; j++) x ^= d[j];
    return x;
  endfunction

  // Plays one frame starting from IDLE; u >= N means no underrun.
  // Expected cycle c outputs follow the frame layout: idle, 15 pre, sfd, payload, fcs/err, ifg.
  task automatic run_frame(input pay_t d, input int u, input logic [3:0] fcs);
    int         lim, len, last_rdy;
    logic [3:0] et;
    logic       ee, er, rr, bb;
    bit         seen = 0;
    lim      = (u < N) ? u : N;
    len      = 18 + lim + IFG;
    last_rdy = 16 + ((u < N) ? u : N - 1);
    for (int c = 0; c < len; c++) begin
      et = 4'h0; ee = 1'b0; er = 1'b0;
      if (c >= 1 && c <= 15) begin et = 4'h5; ee = 1'b1; end
      else if (c == 16) begin et = 4'hD; ee = 1'b1; end
      else if (c >= 17 && c < 17 + lim) begin et = d[c - 17]; ee = 1'b1; end
      else if (c == 17 + lim) begin
        ee = 1'b1;
        if (u < N) er = 1'b1; else et = fcs;
      end
      rr = (c >= 16) && (c <= last_rdy);
      bb = (c != 0);
      check("frame_out{txd,en,er,rdy,busy}", 32'({txd, tx_en, tx_er, in_ready, busy}),
            32'({et, ee, er, rr, bb}));
      if (!seen && c >= 1 && tx_en) begin seen = 1; start_obs = cyc; end
      in_valid = 1'($urandom);
      in_data  = 4'($urandom);
      if (c == 0) in_valid = 1'b1;
      else if (c >= 16 && c <= 16 + N - 1) begin
        if (c - 16 == u) in_valid = 1'b0;
        else if (c - 16 < lim) begin in_valid = 1'b1; in_data = d[c - 16]; end
      end
      step();
    end
    if (u < N) m_under = (m_under == 8'hFF) ? 8'hFF : m_under + 8'd1;
    else m_frames = m_frames + 8'd1;
    check("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    check("underrun_cnt", 32'(underrun_cnt), 32'(m_under));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      check("idle_out", 32'({txd, tx_en, tx_er, in_ready, busy}), 32'd0);
      step();
    end
  endtask

  initial begin
    vec_t       tbl [7];
    pay_t       d;
    int         u, s1, k, rcnt;
    logic [3:0] vals [3];
    logic [3:0] last;
    logic       acc;

    tbl[0] = '{0, 4'h0, N,  4'h0, 8'd1, 8'd0};
    tbl[1] = '{1, 4'hA, N,  4'hA, 8'd2, 8'd0};
    tbl[2] = '{2, 4'h6, N,  4'h5, 8'd3, 8'd0};
    tbl[3] = '{0, 4'h3, 5,  4'h0, 8'd3, 8'd1};
    tbl[4] = '{1, 4'hF, 0,  4'h0, 8'd3, 8'd2};
    tbl[5] = '{2, 4'h1, 15, 4'h0, 8'd3, 8'd3};
    tbl[6] = '{2, 4'hC, N,  4'hF, 8'd4, 8'd3};

    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; v3 = 1'b0; d3 = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'({txd, tx_en, tx_er, in_ready, busy, frame_cnt, underrun_cnt}), 32'd0);
    rst = 1'b0;
    step();
    idle(5);

    // Short-payload instance: 1,2,4 gives FCS 7 and exactly three ready cycles
    vals = '{4'h1, 4'h2, 4'h4};
    k = 0; rcnt = 0; last = 4'h0;
    for (int c = 0; c < 26; c++) begin
      if (ready3) rcnt++;
      if (en3) last = txd3;
      v3  = (c <= 18);
      d3  = (k < 3) ? vals[k] : 4'h0;
      acc = ready3 && v3;
      step();
      if (acc) k++;
    end
    check("p3_fcs", 32'(last), 32'd7);
    check("p3_ready_cycles", 32'(rcnt), 32'd3);
    check("p3_frame_cnt", 32'({fc3, uc3, busy3}), 32'({8'd1, 8'd0, 1'b0}));

    foreach (tbl[i]) begin
      mk(tbl[i].kind, tbl[i].base, d);
      run_frame(d, tbl[i].u, tbl[i].fcs);
      check("tbl_counts", 32'({frame_cnt, underrun_cnt}), 32'({tbl[i].frames, tbl[i].unders}));
    end

    mk(3, 4'h0, d);
    run_frame(d, N, xor_all(d));
    s1 = start_obs;
    mk(3, 4'h0, d);
    run_frame(d, N, xor_all(d));
    check("start_spacing", 32'(start_obs - s1), 32'd58);

    for (int f = 0; f < 40; f++) begin
      mk(3, 4'h0, d);
      u = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : N;
      run_frame(d, u, xor_all(d));
    end

    // Asynchronous reset in the middle of the payload
    in_valid = 1'b1;
    for (int c = 0; c < 22; c++) begin
      in_data = 4'($urandom);
      step();
    end
    #2 rst = 1'b1;
    #1;
    check("async_rst", 32'({txd, tx_en, tx_er, busy, frame_cnt, underrun_cnt}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; m_frames = 8'd0; m_under = 8'd0;
    idle(3);
    mk(3, 4'h0, d);
    run_frame(d, N, xor_all(d));

    for (int f = 0; f < 254; f++) begin
      mk(3, 4'h0, d);
      run_frame(d, N, xor_all(d));
    end
    check("frame_cnt_255", 32'(frame_cnt), 32'hFF);
    mk(3, 4'h0, d);
    run_frame(d, N, xor_all(d));
    check("frame_cnt_wrap", 32'(frame_cnt), 32'd0);

    for (int f = 0; f < 300; f++) begin
      mk(3, 4'h0, d);
      run_frame(d, int'($urandom_range(0, N - 1)), 4'h0);
    end
    check("underrun_sat", 32'({underrun_cnt, frame_cnt}), 32'({8'hFF, 8'd0}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/nibble_frame_tx.md
NIBBLE_FRAME_TX -- requirements
Module: nibble_frame_tx

Interface
REQ-001 Parameter PAYLOAD_NIBBLES, default 16, number of payload nibbles per frame (legal range 1..255).
REQ-002 Parameter IFG_CYCLES, default 24, idle cycles forced after every frame end (legal range 1..255).
REQ-003 Port clk  input  1  clock; all state changes on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port in_data  input  4  payload nibble from the upstream 4-bit counter/source.
REQ-006 Port in_valid  input  1  in_data is valid this cycle.
REQ-007 Port in_ready  output  1  block accepts in_data at the next rising edge; a transfer occurs when in_valid and in_ready are both 1.
REQ-008 Port txd  output  4  MII-style transmit nibble, registered.
REQ-009 Port tx_en  output  1  frame in progress on txd, registered.
REQ-010 Port tx_er  output  1  payload underrun marker, registered.
REQ-011 Port frame_cnt  output  8  count of frames that completed normally; wraps 255->0.
REQ-012 Port underrun_cnt  output  8  count of aborted frames; saturates at 255.
REQ-013 Port busy  output  1  state is not IDLE.

Function
REQ-014 States: IDLE, PRE, SFD, PAYLOAD, FCS, IFG; the txd/tx_en/tx_er registers are updated on the same edge as the state register, so the outputs always reflect the current state.
REQ-015 IDLE: txd=0, tx_en=0, tx_er=0, in_ready=0; an edge with in_valid=1 moves the block to PRE, and that nibble is not consumed.
REQ-016 PRE: lasts exactly 15 cycles; txd=4'h5 and tx_en=1; then moves to SFD.
REQ-017 SFD: lasts 1 cycle; txd=4'hD and tx_en=1; in_ready=1.
REQ-018 PAYLOAD: lasts PAYLOAD_NIBBLES cycles; each cycle shows the nibble accepted on the edge that entered that cycle.
REQ-019 in_ready=1 in SFD and in PAYLOAD cycles 0..PAYLOAD_NIBBLES-2; in_ready=0 in all other cycles (combinational from state and index).
REQ-020 Running checksum: 4-bit XOR of all accepted payload nibbles; it is cleared on entry to PRE.
REQ-021 FCS: lasts 1 cycle; txd=checksum and tx_en=1; then the block moves to IFG and frame_cnt increments.
REQ-022 IFG: lasts IFG_CYCLES cycles; txd=0, tx_en=0, in_ready=0; then the block moves to IDLE, and in_valid during IFG is ignored.
REQ-023 Underrun: if in_ready=1 and in_valid=0 at an edge, the next cycle shows txd=0, tx_en=1, tx_er=1; the block then moves to IFG, FCS is skipped, frame_cnt does not change, and underrun_cnt increments unless it is at 255.
REQ-024 Only one underrun can occur per frame; tx_er=1 lasts exactly one cycle.
REQ-025 A frame from the first preamble cycle to FCS is 15+1+PAYLOAD_NIBBLES+1 cycles with tx_en=1 continuously.
REQ-026 Back-to-back: with in_valid held at 1, frame starts are separated by 18+PAYLOAD_NIBBLES+IFG_CYCLES cycles, including the one IDLE cycle.
REQ-027 busy=1 in every state except IDLE.

Reset
REQ-028 When rst=1, the block immediately enters IDLE, and txd=0, tx_en=0, tx_er=0, frame_cnt=0, underrun_cnt=0, checksum=0, and all index counters=0.
REQ-029 Reset asserted mid-frame aborts the frame without a tx_er cycle and without changing the counters apart from clearing them; the next frame after release starts from PRE.
REQ-030 After rst deasserts, the first transition out of IDLE requires a rising edge with in_valid=1.

Verification
REQ-031 Defaults, in_valid held at 1, in_data = free-running 4-bit count starting at 0 on the first accepted nibble -> 15x 5, D, then 0..F, FCS=0, tx_en high for 33 cycles, then 24 cycles low, frame_cnt=1.
REQ-032 PAYLOAD_NIBBLES=3, data 1,2,4 -> FCS nibble 7; in_ready high for exactly 3 cycles (SFD, P0, P1).
REQ-033 in_valid dropped at payload index 5 -> txd=0 with tx_er=1 at index 5, tx_en falls the next cycle, underrun_cnt=1, frame_cnt unchanged.
REQ-034 rst pulsed during PAYLOAD -> txd/tx_en go to 0 asynchronously and the counters read 0; the next frame is complete and correct.
REQ-035 256 good frames -> frame_cnt wraps to 0; 300 underrun frames -> underrun_cnt stays at 255.
REQ-036 in_valid toggling during IFG -> no tx_en and no in_ready until IDLE; spacing between frame starts equals 58 cycles at defaults.
